// File: rtl/segment_to_binary_monitor.sv
// Passive monitor for a multiplexed active-low 7-segment bus: decodes each settled digit and flags frames/bad glyphs.
// Optional blank-glyph support is enabled by defining SEG_MONITOR_BLANK_DETECT_EN.
module segment_to_binary_monitor #(
  parameter int NUM_DIGITS    = 4,
  parameter int STABLE_CYCLES = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [6:0]              seven_in,
  input  logic [NUM_DIGITS-1:0]   anode_in,
  input  logic                    clear_err,
  output logic [4*NUM_DIGITS-1:0] digits_out,
  output logic [NUM_DIGITS-1:0]   digit_valid,
  output logic [NUM_DIGITS-1:0]   digit_blank,
  output logic                    frame_valid,
  output logic                    pattern_error,
  output logic [1:0]              dbg_state_o
);

  localparam int SW = NUM_DIGITS + 7;
  localparam int CW = $clog2(STABLE_CYCLES + 1);

  typedef enum logic [1:0] {IDLE = 2'd0, TRACK = 2'd1, CAPTURED = 2'd2} state_t;

  state_t                  state_q, state_d;
  logic [CW-1:0]           cnt_q, cnt_d;
  logic [SW-1:0]           samp_q, prev_q;
  logic [4*NUM_DIGITS-1:0] digits_q, digits_d;
  logic [NUM_DIGITS-1:0]   valid_q, valid_d;
  logic [NUM_DIGITS-1:0]   blank_q, blank_d;
  logic [NUM_DIGITS-1:0]   mask_q, mask_d, mask_n;
  logic                    frame_q, frame_d;
  logic                    err_q, err_d;

  logic [NUM_DIGITS-1:0]   sel;
  logic [6:0]              seg;
  logic                    one_hot, same, capture;
  logic                    dec_ok, is_blank;
  logic [3:0]              dec_val;

  assign sel     = ~samp_q[SW-1:7];
  assign seg     = samp_q[6:0];
  assign one_hot = (sel != '0) && ((sel & (sel - 1'b1)) == '0);
  assign same    = (samp_q == prev_q);

  // B and D are drawn identically to 8 and 0, so only one code per shape exists.
  always_comb begin
    dec_ok  = 1'b1;
    dec_val = 4'h0;
    case (seg)
      7'b1000000: dec_val = 4'h0;
      7'b1111001: dec_val = 4'h1;
      7'b0100100: dec_val = 4'h2;
      7'b0110000: dec_val = 4'h3;
      7'b0011001: dec_val = 4'h4;
      7'b0010010: dec_val = 4'h5;
      7'b0000010: dec_val = 4'h6;
      7'b1111000: dec_val = 4'h7;
      7'b0000000: dec_val = 4'h8;
      7'b0010000: dec_val = 4'h9;
      7'b0001000: dec_val = 4'hA;
      7'b1000110: dec_val = 4'hC;
      7'b0000110: dec_val = 4'hE;
      7'b0001110: dec_val = 4'hF;
      default:    dec_ok  = 1'b0;
    endcase
  end

`ifdef SEG_MONITOR_BLANK_DETECT_EN
  assign is_blank = (seg == 7'b1111111);
`else
  assign is_blank = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    capture = 1'b0;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (one_hot) begin
          state_d = TRACK;
          cnt_d   = CW'(1);
        end
      end
      TRACK: begin
        if (!one_hot) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (same) begin
          if (cnt_q == CW'(STABLE_CYCLES - 1)) begin
            capture = 1'b1;
            state_d = CAPTURED;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end else begin
          cnt_d = CW'(1);
        end
      end
      CAPTURED: begin
        if (!one_hot) begin
          state_d = IDLE;
        end else if (!same) begin
          state_d = TRACK;
          cnt_d   = CW'(1);
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_comb begin
    digits_d = digits_q;
    valid_d  = valid_q;
    blank_d  = blank_q;
    mask_d   = mask_q;
    mask_n   = mask_q | sel;
    frame_d  = 1'b0;
    err_d    = clear_err ? 1'b0 : err_q;
    if (capture) begin
      if (dec_ok || is_blank) begin
        for (int i = 0; i < NUM_DIGITS; i++) begin
          if (sel[i]) begin
            if (dec_ok) digits_d[4*i +: 4] = dec_val;
            valid_d[i] = dec_ok;
            blank_d[i] = is_blank;
          end
        end
        // The completing capture both pulses the frame and starts a fresh mask.
        if (&mask_n) begin
          frame_d = 1'b1;
          mask_d  = '0;
        end else begin
          mask_d = mask_n;
        end
      end else begin
        err_d   = 1'b1;
        valid_d = valid_q & ~sel;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      samp_q   <= '1;
      prev_q   <= '1;
      digits_q <= '0;
      valid_q  <= '0;
      blank_q  <= '0;
      mask_q   <= '0;
      frame_q  <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      samp_q   <= {anode_in, seven_in};
      prev_q   <= samp_q;
      digits_q <= digits_d;
      valid_q  <= valid_d;
      blank_q  <= blank_d;
      mask_q   <= mask_d;
      frame_q  <= frame_d;
      err_q    <= err_d;
    end
  end

  assign digits_out    = digits_q;
  assign digit_valid   = valid_q;
  assign digit_blank   = blank_q;
  assign frame_valid   = frame_q;
  assign pattern_error = err_q;
  assign dbg_state_o   = state_q;

endmodule

// File: tb/tb_segment_to_binary_monitor.sv
// Bench for segment_to_binary_monitor: directed plan steps then random scans, checked against a run-length reference model.
module tb_segment_to_binary_monitor;

  localparam int ND = 4;
  localparam int S  = 4;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [6:0]    seven_in = 7'h7f;
  logic [ND-1:0] anode_in = '1;
  logic          clear_err = 1'b0;
  logic [4*ND-1:0] digits_out;
  logic [ND-1:0] digit_valid, digit_blank;
  logic          frame_valid, pattern_error;
  logic [1:0]    dbg_state_o;

  segment_to_binary_monitor #(.NUM_DIGITS(ND), .STABLE_CYCLES(S)) dut (
    .clk(clk), .reset(reset), .seven_in(seven_in), .anode_in(anode_in),
    .clear_err(clear_err), .digits_out(digits_out), .digit_valid(digit_valid),
    .digit_blank(digit_blank), .frame_valid(frame_valid),
    .pattern_error(pattern_error), .dbg_state_o(dbg_state_o)
  );

  always #5 clk = ~clk;

  localparam logic [6:0] PATS [14] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000,
    7'b0001000, 7'b1000110, 7'b0000110, 7'b0001110};
  localparam logic [3:0] VALS [14] = '{4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6,
    4'h7, 4'h8, 4'h9, 4'hA, 4'hC, 4'hE, 4'hF};

`ifdef SEG_MONITOR_BLANK_DETECT_EN
  localparam bit BLANK_EN = 1'b1;
`else
  localparam bit BLANK_EN = 1'b0;
`endif

  // Reference model: the display is a stream of samples; a capture fires when a
  // one-hot run of identical samples has lasted exactly S edges.
  logic [3:0]    m_dig [ND];
  logic [ND-1:0] m_valid, m_blank, m_mask;
  logic          m_frame, m_err;
  logic [ND+6:0] run_val;
  int            run_len;

  int passes = 0;
  int total  = 0;
  int frames_seen = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passes++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  function automatic logic [4*ND-1:0] m_digits();
    logic [4*ND-1:0] r;
    for (int i = 0; i < ND; i++) r[4*i +: 4] = m_dig[i];
    return r;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < ND; i++) m_dig[i] = 4'h0;
    m_valid = '0; m_blank = '0; m_mask = '0; m_frame = 1'b0; m_err = 1'b0;
    run_val = '1; run_len = 1;
  endtask

  task automatic model_edge(input logic [ND-1:0] an, input logic [6:0] sg, input logic clr);
    logic [ND-1:0] low;
    logic [6:0] p;
    logic set_err;
    bit found;
    int d;
    m_frame = 1'b0;
    set_err = 1'b0;
    low = ~run_val[ND+6:7];
    p   = run_val[6:0];
    if (run_len == S && $countones(low) == 1) begin
      d = 0;
      for (int i = 0; i < ND; i++) if (low[i]) d = i;
      found = 0;
      for (int k = 0; k < 14; k++) if (PATS[k] == p) begin found = 1; m_dig[d] = VALS[k]; end
      if (found) begin
        m_valid[d] = 1'b1; m_blank[d] = 1'b0; m_mask[d] = 1'b1;
      end else if (BLANK_EN && p == 7'h7f) begin
        m_valid[d] = 1'b0; m_blank[d] = 1'b1; m_mask[d] = 1'b1;
      end else begin
        set_err = 1'b1; m_valid[d] = 1'b0;
      end
      if (&m_mask) begin m_frame = 1'b1; m_mask = '0; end
    end
    m_err = set_err ? 1'b1 : (clr ? 1'b0 : m_err);
    if ({an, sg} == run_val) begin
      if (run_len <= S) run_len++;
    end else begin
      run_val = {an, sg};
      run_len = 1;
    end
  endtask

  task automatic step(input logic [ND-1:0] an, input logic [6:0] sg, input logic clr, input logic rst);
    anode_in = an; seven_in = sg; clear_err = clr; reset = rst;
    @(posedge clk);
    if (rst) model_reset();
    else model_edge(an, sg, clr);
    #1;
    if (frame_valid === 1'b1) frames_seen++;
    chk("digits_out", 32'(digits_out), 32'(m_digits()));
    chk("digit_valid", 32'(digit_valid), 32'(m_valid));
    chk("digit_blank", 32'(digit_blank), 32'(m_blank));
    chk("frame_valid", 32'(frame_valid), 32'(m_frame));
    chk("pattern_error", 32'(pattern_error), 32'(m_err));
  endtask

  task automatic hold(input logic [ND-1:0] an, input logic [6:0] sg, input int n);
    for (int i = 0; i < n; i++) step(an, sg, 1'b0, 1'b0);
  endtask

  initial begin
    logic [ND-1:0] an;
    logic [6:0] sg;
    int r;
    model_reset();
    step('1, 7'h7f, 1'b0, 1'b1);
    step('1, 7'h7f, 1'b0, 1'b1);
    chk("reset_digits", 32'(digits_out), 32'h0);

    // Single digit 2 on position 0.
    hold(4'b1110, 7'b0100100, 5);
    chk("first_digit", 32'(digits_out[3:0]), 32'h2);
    chk("first_valid", 32'(digit_valid), 32'b0001);

    // Full scan 1,2,3,4.
    frames_seen = 0;
    hold(4'b1110, 7'b1111001, 6);
    hold(4'b1101, 7'b0100100, 6);
    hold(4'b1011, 7'b0110000, 6);
    hold(4'b0111, 7'b0011001, 6);
    chk("scan_digits", 32'(digits_out), 32'h4321);
    chk("scan_frames", 32'(frames_seen), 32'd1);

    // Short 5 glitch then settled 6 on digit 1.
    hold(4'b1101, 7'b0010010, 3);
    hold(4'b1101, 7'b0000010, 5);
    chk("glitch_digit1", 32'(digits_out[7:4]), 32'h6);

    // Two anodes low: FSM idles, nothing changes.
    for (int i = 0; i < 10; i++) begin
      step(4'b1100, 7'b0000000, 1'b0, 1'b0);
      if (i > 1) chk("multi_low_idle", 32'(dbg_state_o), 32'd0);
    end
    hold(4'b1101, 7'b1111000, 5);
    chk("digit1_seven", 32'(digits_out[7:4]), 32'h7);

    // Bad glyph, clear, then clear colliding with a new bad capture.
    hold(4'b1011, 7'b0101010, 5);
    chk("bad_glyph_err", 32'(pattern_error), 32'd1);
    step(4'b1011, 7'b0101010, 1'b1, 1'b0);
    chk("err_cleared", 32'(pattern_error), 32'd0);
    hold(4'b0111, 7'b1010101, 4);
    step(4'b0111, 7'b1010101, 1'b1, 1'b0);
    chk("set_wins", 32'(pattern_error), 32'd1);

    // Reset in the middle of a settling 1 on digit 0.
    hold(4'b1110, 7'b1111001, 3);
    step(4'b1110, 7'b1111001, 1'b0, 1'b1);
    chk("midreset_valid", 32'(digit_valid), 32'd0);
    hold(4'b1110, 7'b1111001, 4);
    chk("no_early_capture", 32'(digit_valid), 32'd0);
    hold(4'b1110, 7'b1111001, 1);
    chk("late_capture", 32'(digits_out[3:0]), 32'h1);

    // Randomised scanning.
    for (int n = 0; n < 120; n++) begin
      r = $urandom_range(0, 9);
      if (r < 8) begin
        an = '1;
        an[$urandom_range(0, ND - 1)] = 1'b0;
      end else begin
        an = ND'($urandom);
      end
      r = $urandom_range(0, 9);
      if (r < 7) sg = PATS[$urandom_range(0, 13)];
      else if (r < 8) sg = 7'h7f;
      else sg = 7'($urandom);
      r = $urandom_range(1, 7);
      for (int k = 0; k < r; k++)
        step(an, sg, ($urandom_range(0, 9) == 0), ($urandom_range(0, 199) == 0));
    end

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule

// File: doc/segment_to_binary_monitor.md
Name: segment_to_binary_monitor

Overview:
- Passive self-test monitor on the multiplexed 7-segment display bus of the kitchen timer.
- Samples the active-low segment lines and the active-low digit anodes.
- Waits for each digit's pattern to settle, decodes it back to a 4-bit value and stores it per digit position.
- Flags a completed display frame and any pattern outside the display's glyph set, so the bench or a BIST checker can compare shown digits against the timer count.

Parameters:
- NUM_DIGITS, 4, number of multiplexed digit positions (anode lines).
- STABLE_CYCLES, 4, consecutive identical samples required before a capture (minimum 2).

Ports:
- clk  input  1  system clock, all logic on the rising edge.
- reset  input  1  synchronous, active-high; clears all state.
- seven_in  input  7  segment lines, active-low; bit 6 = G, bit 0 = A.
- anode_in  input  NUM_DIGITS  digit enables, active-low; a valid scan has exactly one bit low.
- clear_err  input  1  one-cycle pulse that clears pattern_error.
- digits_out  output  4*NUM_DIGITS  decoded values; digit i occupies bits [4i+3:4i].
- digit_valid  output  NUM_DIGITS  bit i set once digit i holds a decoded value.
- digit_blank  output  NUM_DIGITS  bit i set when digit i was last seen blank (see Optional Feature).
- frame_valid  output  1  one-cycle pulse when every digit has been captured since the last pulse.
- pattern_error  output  1  sticky; set when an unrecognized pattern is captured.

Behaviour:
- Reset: digits_out=0, digit_valid=0, digit_blank=0, frame_valid=0, pattern_error=0. Seen-mask=0, stability counter=0, FSM=IDLE, input sample registers=all ones. Reset mid-capture abandons the capture with no partial update.
- Input stage: {anode_in, seven_in} registered every cycle. All decisions use the registered sample compared against the previous registered sample.
- FSM states:
  - IDLE: sample anode is not exactly one-hot-low, i.e. all high or multiple low. Counter held at 0. Stays here until a one-hot-low anode sample arrives, then goes to TRACK with counter=1.
  - TRACK: if the sample equals the previous sample, counter increments. When counter reaches STABLE_CYCLES, capture happens and the FSM goes to CAPTURED. If the sample changes but is still one-hot, counter=1 and the FSM stays in TRACK. If the anode is not one-hot, go to IDLE.
  - CAPTURED: holds while the sample is unchanged; no repeated capture. Any change goes to TRACK (counter=1) or to IDLE, per the same rules.
- Latency: a pattern first present before edge k and held is sampled at edges k..k+STABLE_CYCLES-1. Outputs update at edge k+STABLE_CYCLES.
- Decode (seven_in pattern -> value):
  - 1000000->0, 1111001->1, 0100100->2, 0110000->3, 0011001->4, 0010010->5, 0000010->6, 1111000->7.
  - 0000000->8, 0010000->9, 0001000->A, 1000110->C, 0000110->E, 0001110->F.
  - The display cannot distinguish B from 8 or D from 0, so those glyphs decode to 8 and 0.
- Capture on a recognized pattern for digit i:
  - digits_out[i] gets the value, digit_valid[i]=1, digit_blank[i]=0.
  - Seen-mask bit i is set. Re-capturing an already-seen digit updates its value; the mask is unchanged.
- Capture on an unrecognized pattern:
  - pattern_error=1, digit_valid[i]=0, digits_out[i] unchanged.
  - Mask bit i is not set.
- Frame completion: when the mask, including the current capture, is all ones, frame_valid pulses for one cycle on the same edge as the final capture, and the mask clears to 0.
- clear_err and a new error on the same edge: pattern_error stays 1, because set wins.

Optional Feature:
- Macro: SEG_MONITOR_BLANK_DETECT_EN.
- Defined: pattern 1111111 is a legal blank. Capture sets digit_blank[i]=1, digit_valid[i]=0 and mask bit i, with no error and digits_out[i] unchanged.
- Undefined: digit_blank is held at 0, and 1111111 is treated as an unrecognized pattern, which sets pattern_error.

Test Plan:
- Reset, then anode_in=1110 with seven_in=0100100 held 4 cycles -> at edge 4, digits_out[3:0]=2 and digit_valid=0001; frame_valid stays 0.
- Scan digits 0..3 with 1,2,3,4, each held 6 cycles -> digits_out=16'h4321, frame_valid high exactly one cycle at digit 3's capture, and pattern_error=0.
- Digit 1 shows 0010010 for 3 cycles, then 0000010 for 4 cycles -> 5 is never captured; digit 1 captures 6.
- anode_in=1100 (two low) held 10 cycles -> FSM stays in IDLE with no output change; then 1101 with 1111000 for 4 cycles -> digit 1 = 7.
- Digit 2 pattern 0101010 held 4 cycles -> pattern_error=1 and digit_valid[2]=0. Then clear_err pulse -> 0. Then clear_err on the same edge as a new bad capture -> stays 1.
- Assert reset during cycle 3 of a stable 1111001 on digit 0 -> all outputs 0, and no capture occurs after reset releases until 4 new stable samples.
